// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
// Bundles the two requester ports (CPU load/store stage on port 0 and
// debug/loader on port 1) together with the command/strobe/data
// signals that run between the arbiter and data_memory.
//   slave  : the arbiter side. It takes the requests and read_data, and it
//            drives the acks, the errors, the load data and the memory commands.
//   master : the requester/memory side (mirror of slave).
interface data_mem_arbiter_if;
    // requester port 0
    logic        p0_req;
    logic        p0_we;
    logic [2:0]  p0_funct3;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;
    // requester port 1
    logic        p1_req;
    logic        p1_we;
    logic [2:0]  p1_funct3;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;
    // memory side
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] endereco;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport slave (
        input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
        input  read_data,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output MemRead, MemWrite, funct3, endereco, write_data
    );

    modport master (
        output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
        output read_data,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  MemRead, MemWrite, funct3, endereco, write_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single data_memory port between two requesters. It uses
// round-robin arbitration. It rejects illegal, misaligned and out-of-range
// accesses before they reach the memory. Every access, whether it is a load,
// a store or a rejected access, completes with a one-cycle ack in the third
// cycle after the grant edge.
// Ports:
//   clock : rising-edge clock, shared with data_memory
//   reset : asynchronous, active-high
//   bus   : data_mem_arbiter_if.slave, which carries the requester handshakes
//           (pN_*) and the memory command/strobe/read-data signals
module data_mem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Byte count of an access; 0 marks an illegal size code.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        logic [2:0] size;
        case (f3)
            3'b000:  size = 3'd1;
            3'b001:  size = 3'd2;
            3'b010:  size = 3'd4;
            default: size = 3'd0;
        endcase
        return size;
    endfunction

    // An access is rejected when the size code is illegal, the address is
    // misaligned, or the access runs past the end of memory. The end address
    // is formed in 33 bits, so an address near 2^32 cannot wrap back into range.
    function automatic logic access_bad(input logic [2:0] f3, input logic [31:0] addr);
        logic [2:0]  size;
        logic [32:0] end_addr;
        logic        misaligned;
        size     = access_size(f3);
        end_addr = {1'b0, addr} + {30'd0, size};
        case (f3)
            3'b001:  misaligned = addr[0];
            3'b010:  misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return (size == 3'd0) | misaligned | (end_addr > 33'(MEM_BYTES));
    endfunction

    state_t      state_r;
    logic        owner_r;
    logic        bad_r;
    logic        last_grant_r;
    logic        cmd_we_r;
    logic [2:0]  cmd_funct3_r;
    logic [31:0] cmd_addr_r;
    logic [31:0] cmd_wdata_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        p0_ack_r;
    logic        p0_err_r;
    logic [31:0] p0_rdata_r;
    logic        p1_ack_r;
    logic        p1_err_r;
    logic [31:0] p1_rdata_r;

    logic        elig0_s;
    logic        elig1_s;
    logic        grant_valid_s;
    logic        grant_port_s;
    logic        sel_we_s;
    logic [2:0]  sel_funct3_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_bad_s;

    // A port is masked in its own ack cycle. This keeps a requester that is
    // still lowering req from being granted a second time.
    assign elig0_s = bus.p0_req & ~p0_ack_r;
    assign elig1_s = bus.p1_req & ~p1_ack_r;

    // Grant selection: a lone eligible port wins; a tie goes to the port that was not granted last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        if (elig0_s && elig1_s) begin
            grant_valid_s = 1'b1;
            grant_port_s  = ~last_grant_r;
        end else if (elig0_s) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b0;
        end else if (elig1_s) begin
            grant_valid_s = 1'b1;
            grant_port_s  = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_port_s  = 1'b0;
        end
    end

    assign sel_we_s     = grant_port_s ? bus.p1_we     : bus.p0_we;
    assign sel_funct3_s = grant_port_s ? bus.p1_funct3 : bus.p0_funct3;
    assign sel_addr_s   = grant_port_s ? bus.p1_addr   : bus.p0_addr;
    assign sel_wdata_s  = grant_port_s ? bus.p1_wdata  : bus.p0_wdata;
    assign sel_bad_s    = access_bad(sel_funct3_s, sel_addr_s);

    // Sequencer IDLE -> ISSUE -> RESP, with all memory and requester outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            bad_r        <= 1'b0;
            last_grant_r <= 1'b1;
            cmd_we_r     <= 1'b0;
            cmd_funct3_r <= 3'd0;
            cmd_addr_r   <= 32'd0;
            cmd_wdata_r  <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            p0_ack_r     <= 1'b0;
            p0_err_r     <= 1'b0;
            p0_rdata_r   <= 32'd0;
            p1_ack_r     <= 1'b0;
            p1_err_r     <= 1'b0;
            p1_rdata_r   <= 32'd0;
        end else begin
            // Acks and errs are single-cycle pulses unless RESP sets them again.
            p0_ack_r <= 1'b0;
            p0_err_r <= 1'b0;
            p1_ack_r <= 1'b0;
            p1_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        owner_r      <= grant_port_s;
                        last_grant_r <= grant_port_s;
                        bad_r        <= sel_bad_s;
                        cmd_we_r     <= sel_we_s;
                        cmd_funct3_r <= sel_funct3_s;
                        cmd_addr_r   <= sel_addr_s;
                        cmd_wdata_r  <= sel_wdata_s;
                        // A rejected access never raises a strobe.
                        mem_read_r   <= ~sel_we_s & ~sel_bad_s;
                        mem_write_r  <= sel_we_s & ~sel_bad_s;
                        state_r      <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    // The memory registers read_data, so it is valid in this cycle.
                    if (owner_r) begin
                        p1_ack_r <= 1'b1;
                        p1_err_r <= bad_r;
                        if (!cmd_we_r) begin
                            p1_rdata_r <= bad_r ? 32'd0 : bus.read_data;
                        end else begin
                            p1_rdata_r <= p1_rdata_r;
                        end
                    end else begin
                        p0_ack_r <= 1'b1;
                        p0_err_r <= bad_r;
                        if (!cmd_we_r) begin
                            p0_rdata_r <= bad_r ? 32'd0 : bus.read_data;
                        end else begin
                            p0_rdata_r <= p0_rdata_r;
                        end
                    end
                    cmd_funct3_r <= 3'd0;
                    cmd_addr_r   <= 32'd0;
                    cmd_wdata_r  <= 32'd0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_ack     = p0_ack_r;
    assign bus.p0_err     = p0_err_r;
    assign bus.p0_rdata   = p0_rdata_r;
    assign bus.p1_ack     = p1_ack_r;
    assign bus.p1_err     = p1_err_r;
    assign bus.p1_rdata   = p1_rdata_r;
    assign bus.MemRead    = mem_read_r;
    assign bus.MemWrite   = mem_write_r;
    assign bus.funct3     = cmd_funct3_r;
    assign bus.endereco   = cmd_addr_r;
    assign bus.write_data = cmd_wdata_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// The bench drives table vectors through data_mem_arbiter and models
// data_memory as a little-endian byte array with registered read data.
// Each completed access is matched against a scoreboard queue. The bench
// also runs hand-written sequences for contention, ack-cycle masking and
// reset during ISSUE.
module tb_data_mem_arbiter;

    logic clock;
    logic reset;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.MEM_BYTES(1024)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[15];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // data_memory model: byte-addressed storage with read data registered on the clock.
    logic [7:0] mem [0:1023];
    logic [9:0] ma;
    assign ma = bus.endereco[9:0];
    always @(posedge clock) begin
        if (bus.MemWrite) begin
            case (bus.funct3)
                3'b000: mem[ma] <= bus.write_data[7:0];
                3'b001: begin
                    mem[ma]         <= bus.write_data[7:0];
                    mem[ma + 10'd1] <= bus.write_data[15:8];
                end
                3'b010: begin
                    mem[ma]         <= bus.write_data[7:0];
                    mem[ma + 10'd1] <= bus.write_data[15:8];
                    mem[ma + 10'd2] <= bus.write_data[23:16];
                    mem[ma + 10'd3] <= bus.write_data[31:24];
                end
                default: ;
            endcase
        end
        if (bus.MemRead) begin
            case (bus.funct3)
                3'b000:  bus.read_data <= {24'd0, mem[ma]};
                3'b001:  bus.read_data <= {16'd0, mem[ma + 10'd1], mem[ma]};
                3'b010:  bus.read_data <= {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
                default: bus.read_data <= 32'd0;
            endcase
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input logic p);
        return p ? bus.p1_ack : bus.p0_ack;
    endfunction

    function automatic logic get_err(input logic p);
        return p ? bus.p1_err : bus.p0_err;
    endfunction

    function automatic logic [31:0] get_rdata(input logic p);
        return p ? bus.p1_rdata : bus.p0_rdata;
    endfunction

    function automatic logic all_outputs_zero();
        return ({bus.p0_ack, bus.p0_err, bus.p0_rdata, bus.p1_ack, bus.p1_err, bus.p1_rdata,
                 bus.MemRead, bus.MemWrite, bus.funct3, bus.endereco, bus.write_data} == 137'd0);
    endfunction

    task automatic drive(input logic p, input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_funct3 = f3; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_funct3 = f3; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pops the oldest expected completion and compares it with the port that acked.
    task automatic pop_and_check(input string name, input logic act_port);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected ack on port %0d, required none", name, act_port);
        end else begin
            e = sbq.pop_front();
            check1({name, " port"}, act_port, e.port);
            check1({name, " err"}, get_err(act_port), e.err);
            check32({name, " rdata"}, get_rdata(act_port), e.rdata);
        end
    endtask

    // Runs one access from an idle arbiter and checks latency, strobes and the completion.
    task automatic do_access(input vec_t v, input string name);
        int cyc;
        int rd_cnt;
        int wr_cnt;
        bit got;
        drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
        sbq.push_back('{v.port, v.exp_err, v.exp_rdata});
        cyc = 0; rd_cnt = 0; wr_cnt = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            step();
            cyc++;
            rd_cnt += int'(bus.MemRead);
            wr_cnt += int'(bus.MemWrite);
            if (get_ack(v.port)) begin
                got = 1'b1;
                pop_and_check(name, v.port);
            end
        end
        if (!got) begin
            void'(sbq.pop_front());
        end
        check32({name, " ack latency"}, 32'(cyc), 32'd3);
        check32({name, " MemRead cycles"}, 32'(rd_cnt), {31'd0, ~v.we & ~v.exp_err});
        check32({name, " MemWrite cycles"}, 32'(wr_cnt), {31'd0, v.we & ~v.exp_err});
        drive(v.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    initial begin
        int ack_cnt;
        int cyc;
        int act_cnt;
        logic [31:0] next_addr;
        bit chk_next;

        //            port  we    f3      addr           wdata          err   rdata
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'd8,         32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 3'b010, 32'd8,         32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'd2,         32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'd1023,      32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 3'b011, 32'd0,         32'h0,        1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'd1023,      32'h000000A5, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 32'd1023,      32'h0,        1'b0, 32'h000000A5};
        vecs[7]  = '{1'b1, 1'b1, 3'b001, 32'd20,        32'h0000CAFE, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'd20,        32'h0,        1'b0, 32'h0000CAFE};
        vecs[9]  = '{1'b0, 1'b0, 3'b010, 32'hFFFFFFFC,  32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 32'd1020,      32'h11223344, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 3'b010, 32'd1020,      32'h0,        1'b0, 32'h11223344};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'd1021,      32'h55555555, 1'b1, 32'h0000CAFE};
        vecs[13] = '{1'b0, 1'b1, 3'b010, 32'd16,        32'h0BADF00D, 1'b0, 32'h11223344};
        vecs[14] = '{1'b1, 1'b0, 3'b000, 32'd8,         32'h0,        1'b0, 32'h000000EF};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #12;
        check1("reset outputs zero", all_outputs_zero(), 1'b1);
        reset = 1'b0;
        step();
        check1("idle outputs zero", all_outputs_zero(), 1'b1);

        for (int i = 0; i < 15; i++) begin
            do_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Contention: both ports keep requesting loads and must alternate, starting with port 0.
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'd8, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'd1020, 32'd0);
        sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        sbq.push_back('{1'b1, 1'b0, 32'h11223344});
        sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        sbq.push_back('{1'b1, 1'b0, 32'h11223344});
        ack_cnt = 0; cyc = 0; chk_next = 1'b0; next_addr = 32'd0;
        while (ack_cnt < 4 && cyc < 20) begin
            step();
            cyc++;
            if (chk_next) begin
                check1("rr same-cycle grant strobe", bus.MemRead, 1'b1);
                check32("rr same-cycle grant addr", bus.endereco, next_addr);
                chk_next = 1'b0;
            end
            if (bus.p0_ack && bus.p1_ack) begin
                check1("rr double ack", 1'b1, 1'b0);
            end else if (bus.p0_ack || bus.p1_ack) begin
                ack_cnt++;
                pop_and_check($sformatf("rr ack%0d", ack_cnt), bus.p1_ack);
                check32($sformatf("rr ack%0d cycle", ack_cnt), 32'(cyc), 32'(3 * ack_cnt));
                next_addr = bus.p0_ack ? 32'd1020 : 32'd8;
                chk_next  = (ack_cnt < 4);
            end else begin
                chk_next = chk_next;
            end
        end
        check32("rr ack count", 32'(ack_cnt), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        sbq.delete();
        act_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            act_cnt += int'(bus.p0_ack | bus.p1_ack | bus.MemRead | bus.MemWrite);
        end
        check32("rr quiet after drop", 32'(act_cnt), 32'd0);

        // Port 0 holds req through its ack cycle: the regrant waits one edge.
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'd8, 32'd0);
        sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        repeat (3) step();
        check1("hold first ack", bus.p0_ack, 1'b1);
        if (bus.p0_ack) pop_and_check("hold ack1", 1'b0);
        step();
        check1("hold no grant in ack cycle", bus.MemRead, 1'b0);
        step();
        check1("hold regrant next edge", bus.MemRead, 1'b1);
        repeat (2) step();
        check1("hold second ack", bus.p0_ack, 1'b1);
        if (bus.p0_ack) pop_and_check("hold ack2", 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        sbq.delete();
        step();

        // Reset pulsed during the ISSUE cycle of a store: no write, no ack.
        drive(1'b0, 1'b1, 1'b1, 3'b010, 32'd16, 32'h12345678);
        step();
        check1("rst store strobe up", bus.MemWrite, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check1("rst outputs zero at once", all_outputs_zero(), 1'b1);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        reset = 1'b0;
        act_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            act_cnt += int'(bus.p0_ack | bus.p1_ack | bus.MemWrite);
        end
        check32("rst no ack no write", 32'(act_cnt), 32'd0);
        do_access('{1'b0, 1'b0, 3'b010, 32'd16, 32'h0, 1'b0, 32'h0BADF00D}, "rst reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
